arb_mux: RTL

Parametrised N-channel arbitrated multiplexer with valid/ready handshakes on every input and on the single output, and a registered output stage. It generalises the plain 4:1 select mux. The select is no longer driven externally: an internal arbiter chooses the channel. The grant is held for the duration of a multi-beat packet. It sits between several producers and one shared downstream consumer.

---
 rtl/arb_mux_pkg.sv | 14 +
 rtl/arb_mux_rr_arbiter.sv | 36 +++
 rtl/arb_mux.sv | 123 ++++++++++++
 3 files changed

// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arbitrated multiplexer.
package arb_mux_pkg;

    typedef enum logic {IDLE, LOCK} arb_state_t;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Index width for a channel count; a single channel still gets one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational arbiter: scans requests starting at the priority pointer
// (round-robin) or at index 0 (fixed priority) and returns a one-hot grant.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int MODE = MODE_RR,
    localparam int SW  = sel_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [N_CH-1:0] grant,
    output logic [SW-1:0]   idx
);

    int  base_idx;
    int  cand;
    logic hit;

    always_comb begin
        grant    = '0;
        idx      = '0;
        hit      = 1'b0;
        cand     = 0;
        base_idx = (MODE == MODE_RR && N_CH > 1) ? int'(ptr) : 0;
        for (int off = 0; off < N_CH; off++) begin
            cand = (base_idx + off) % N_CH;
            if (!hit && req[cand]) begin
                hit         = 1'b1;
                grant[cand] = 1'b1;
                idx         = SW'(cand);
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrated mux: arbiter picks a channel, the grant is held for a
// whole packet, and the chosen beat lands in a single registered output stage.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = MODE_RR,
    localparam int SW   = sel_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH-1:0]       in_last,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [SW-1:0]         out_sel
);

    arb_state_t       state_reg;
    logic [SW-1:0]    lock_ch_reg;
    logic [SW-1:0]    ptr_reg;
    logic             out_valid_reg;
    logic             out_last_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [SW-1:0]    out_sel_reg;

    logic [WIDTH-1:0] ch_data [N_CH];
    logic [N_CH-1:0]  arb_grant;
    logic [SW-1:0]    arb_idx;
    logic [N_CH-1:0]  grant;
    logic [SW-1:0]    gnt_idx;
    logic             load_ok;
    logic             accept;
    logic             gnt_last;
    logic [WIDTH-1:0] gnt_data;
    logic [SW-1:0]    ptr_next;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .N_CH (N_CH),
        .MODE (MODE)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // While locked only the owning channel may be served; if it drops valid
    // the block bubbles rather than letting another channel interleave.
    always_comb begin
        grant   = arb_grant;
        gnt_idx = arb_idx;
        if (state_reg == LOCK) begin
            grant              = '0;
            grant[lock_ch_reg] = in_valid[lock_ch_reg];
            gnt_idx            = lock_ch_reg;
        end
    end

    assign load_ok  = !out_valid_reg || out_ready;
    assign in_ready = (rst_n && load_ok) ? grant : '0;
    assign accept   = |in_ready;
    assign gnt_last = in_last[gnt_idx];
    assign gnt_data = ch_data[gnt_idx];
    assign ptr_next = (gnt_idx == SW'(N_CH - 1)) ? '0 : SW'(gnt_idx + 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lock_ch_reg   <= '0;
            ptr_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
        end else begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= gnt_data;
                out_last_reg  <= gnt_last;
                out_sel_reg   <= gnt_idx;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (accept && !gnt_last) begin
                        state_reg   <= LOCK;
                        lock_ch_reg <= gnt_idx;
                    end
                end
                LOCK: begin
                    if (accept && gnt_last) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (MODE == MODE_RR && accept && gnt_last) begin
                ptr_reg <= ptr_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign out_sel   = (N_CH == 1) ? '0 : out_sel_reg;

endmodule
